// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and defaults.
package hazard_control_pkg;

    typedef enum logic {
        StRun,
        StMemWait
    } state_e;

    localparam int unsigned TimeoutDefault = 255;
    localparam int unsigned WaitCntWidth   = 8;

endpackage

// File: rtl/hazard_control_if.sv
// Hazard-control signal bundle: pipeline hazard inputs and stage-register controls.
interface hazard_control_if;

    logic        idexMemRead;
    logic [4:0]  idexRegisterTarget;
    logic [4:0]  ifidRegisterSource;
    logic [4:0]  ifidRegisterTarget;
    logic        branchTaken;
    logic        memRequest;
    logic        memReady;

    logic        pcWrite;
    logic        ifidWrite;
    logic        idexWrite;
    logic        exmemWrite;
    logic        idexBubble;
    logic        ifidFlush;
    logic        idexFlush;
    logic        exmemFlush;
    logic        memTimeout;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    modport master (
        output idexMemRead, idexRegisterTarget, ifidRegisterSource, ifidRegisterTarget,
        output branchTaken, memRequest, memReady,
        input  pcWrite, ifidWrite, idexWrite, exmemWrite, idexBubble,
        input  ifidFlush, idexFlush, exmemFlush, memTimeout, stallCount, flushCount
    );

    modport slave (
        input  idexMemRead, idexRegisterTarget, ifidRegisterSource, ifidRegisterTarget,
        input  branchTaken, memRequest, memReady,
        output pcWrite, ifidWrite, idexWrite, exmemWrite, idexBubble,
        output ifidFlush, idexFlush, exmemFlush, memTimeout, stallCount, flushCount
    );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that increments on enable and holds at all-ones.
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] count
);

    logic [15:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else if (en && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use stall.
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic             clock,
    input  logic             reset,
    hazard_control_if.slave  hz
);

    localparam logic [WaitCntWidth-1:0] TimeoutVal = WaitCntWidth'(TIMEOUT);

    state_e                  state_q, state_d;
    logic [WaitCntWidth-1:0] wait_cnt_q;
    logic                    timeout_q;
    logic                    load_use;
    logic                    stall;
    logic                    flush;
    logic                    freeze;

    assign load_use = hz.idexMemRead && (hz.idexRegisterTarget != 5'd0) &&
                      ((hz.idexRegisterTarget == hz.ifidRegisterSource) ||
                       (hz.idexRegisterTarget == hz.ifidRegisterTarget));

    always_comb begin
        state_d = state_q;
        freeze  = 1'b0;
        flush   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (hz.memRequest && !hz.memReady) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                end else if (hz.branchTaken) begin
                    flush = 1'b1;
                end else if (load_use) begin
                    stall = 1'b1;
                end
            end
            StMemWait: begin
                // Branches seen here are dropped; the frozen MEM stage re-presents them.
                if (hz.memReady) begin
                    state_d = StRun;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if ((state_q == StRun) && (state_d == StMemWait)) begin
                wait_cnt_q <= '0;
            end else if ((state_q == StMemWait) && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if ((state_q == StMemWait) && (wait_cnt_q == TimeoutVal)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign hz.pcWrite    = !(freeze || stall);
    assign hz.ifidWrite  = !(freeze || stall);
    assign hz.idexWrite  = !freeze;
    assign hz.exmemWrite = !freeze;
    assign hz.idexBubble = stall;
    assign hz.ifidFlush  = flush;
    assign hz.idexFlush  = flush;
    assign hz.exmemFlush = flush;
    assign hz.memTimeout = timeout_q;

    sat_counter16 u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .en    (stall),
        .count (hz.stallCount)
    );

    sat_counter16 u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .en    (flush),
        .count (hz.flushCount)
    );

endmodule

// File: tb/tb_hazard_control.sv
// Directed checks of hazard_control: stalls, flushes, memory wait, timeout and reset.
module tb_hazard_control;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_bad;

    hazard_control_if hz ();

    hazard_control #(
        .TIMEOUT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    // {pcWrite, ifidWrite, idexWrite, exmemWrite, idexBubble, ifidFlush, idexFlush, exmemFlush}
    logic [7:0] ctrl;
    assign ctrl = {hz.pcWrite, hz.ifidWrite, hz.idexWrite, hz.exmemWrite,
                   hz.idexBubble, hz.ifidFlush, hz.idexFlush, hz.exmemFlush};

    localparam logic [7:0] CtrlIdle   = 8'b1111_0000;
    localparam logic [7:0] CtrlStall  = 8'b0011_1000;
    localparam logic [7:0] CtrlFlush  = 8'b1111_0111;
    localparam logic [7:0] CtrlFrozen = 8'b0000_0000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] tgt, input logic [4:0] src,
                         input logic [4:0] rt, input logic br, input logic req,
                         input logic rdy);
        hz.idexMemRead        = mr;
        hz.idexRegisterTarget = tgt;
        hz.ifidRegisterSource = src;
        hz.ifidRegisterTarget = rt;
        hz.branchTaken        = br;
        hz.memRequest         = req;
        hz.memReady           = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        reset    = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ctrl", 32'(ctrl), 32'(CtrlIdle));
        check("reset_stall_cnt", 32'(hz.stallCount), 32'd0);
        check("reset_flush_cnt", 32'(hz.flushCount), 32'd0);
        check("reset_timeout", 32'(hz.memTimeout), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Load-use on rs
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("lu_rs_ctrl", 32'(ctrl), 32'(CtrlStall));
        next_cycle();
        drive(1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("lu_rs_release", 32'(ctrl), 32'(CtrlIdle));
        check("lu_rs_cnt", 32'(hz.stallCount), 32'd1);

        // Load-use on rt
        next_cycle();
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("lu_rt_ctrl", 32'(ctrl), 32'(CtrlStall));
        next_cycle();
        drive(1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("lu_rt_cnt", 32'(hz.stallCount), 32'd2);

        // Register 0 never stalls
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("r0_ctrl", 32'(ctrl), 32'(CtrlIdle));
        next_cycle();
        check("r0_cnt", 32'(hz.stallCount), 32'd2);

        // Load without a match, and a match without a load
        drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("nomatch_ctrl", 32'(ctrl), 32'(CtrlIdle));
        next_cycle();
        drive(1'b0, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("noload_ctrl", 32'(ctrl), 32'(CtrlIdle));

        // Branch beats load-use
        next_cycle();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("br_ctrl", 32'(ctrl), 32'(CtrlFlush));
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("br_flush_cnt", 32'(hz.flushCount), 32'd1);
        check("br_stall_cnt", 32'(hz.stallCount), 32'd2);

        // Memory wait for 3 cycles, branch and hazard ignored while frozen
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("mw_c1", 32'(ctrl), 32'(CtrlFrozen));
        next_cycle();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        check("mw_c2", 32'(ctrl), 32'(CtrlFrozen));
        next_cycle();
        @(negedge clock);
        check("mw_c3", 32'(ctrl), 32'(CtrlFrozen));
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        check("mw_release", 32'(ctrl), 32'(CtrlIdle));
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("mw_timeout", 32'(hz.memTimeout), 32'd0);
        check("mw_flush_cnt", 32'(hz.flushCount), 32'd1);
        check("mw_stall_cnt", 32'(hz.stallCount), 32'd2);

        // Six-cycle wait with TIMEOUT=4 sets the sticky flag
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clock);
            check($sformatf("to_frozen_%0d", i), 32'(ctrl), 32'(CtrlFrozen));
        end
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        check("to_release", 32'(ctrl), 32'(CtrlIdle));
        check("to_set", 32'(hz.memTimeout), 32'd1);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) next_cycle();
        check("to_sticky", 32'(hz.memTimeout), 32'd1);

        // Reset in the middle of a wait
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clock);
        check("rst_pre_frozen", 32'(ctrl), 32'(CtrlFrozen));
        #1;
        reset = 1'b1;
        #1;
        check("rst_timeout", 32'(hz.memTimeout), 32'd0);
        check("rst_stall_cnt", 32'(hz.stallCount), 32'd0);
        check("rst_flush_cnt", 32'(hz.flushCount), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("rst_run_ctrl", 32'(ctrl), 32'(CtrlIdle));
        next_cycle();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("rst_run_stall", 32'(ctrl), 32'(CtrlStall));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter TIMEOUT, default 255: memory-wait cycle count that sets memTimeout.
REQ-002 clock  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 idexMemRead  input  1  load currently in ID/EX (memory-read control bit).
REQ-005 idexRegisterTarget  input  5  rt of the instruction in ID/EX.
REQ-006 ifidRegisterSource  input  5  rs of the instruction in IF/ID.
REQ-007 ifidRegisterTarget  input  5  rt of the instruction in IF/ID.
REQ-008 branchTaken  input  1  branch resolved taken in MEM.
REQ-009 memRequest  input  1  MEM stage has an active data-memory access.
REQ-010 memReady  input  1  data memory completes the access this cycle.
REQ-011 pcWrite, ifidWrite, idexWrite, exmemWrite  output  1 each  stage-register enables.
REQ-012 idexBubble  output  1  zero the WB/M/EX control bits entering ID/EX.
REQ-013 ifidFlush, idexFlush, exmemFlush  output  1 each  squash the stage register.
REQ-014 memTimeout  output  1  sticky flag: a memory wait reached TIMEOUT cycles.
REQ-015 stallCount  output  16  saturating count of load-use bubble cycles.
REQ-016 flushCount  output  16  saturating count of branch-flush events.

Function
REQ-017 The FSM SHALL have two states: RUN and MEMWAIT.
REQ-018 Write enables SHALL default to 1; bubble and flush outputs to 0.
REQ-019 Priority, highest first: memory wait, branch flush, load-use stall.
REQ-020 Memory wait: in RUN, memRequest=1 with memReady=0 SHALL drive all four write enables to 0 combinationally and move the FSM to MEMWAIT.
REQ-021 In MEMWAIT all write enables SHALL stay 0; no flush or bubble output SHALL assert.
REQ-022 In MEMWAIT, memReady=1 SHALL restore the enables in that same cycle and return the FSM to RUN on the next edge.
REQ-023 An 8-bit wait counter SHALL clear on entry to MEMWAIT, increment each MEMWAIT cycle and saturate.
REQ-024 memTimeout SHALL set when the wait counter equals TIMEOUT, and clear only on reset.
REQ-025 Branch flush: in RUN, with no memory wait, branchTaken=1 SHALL assert ifidFlush, idexFlush and exmemFlush for that cycle.
REQ-026 A branch flush SHALL increment flushCount by 1.
REQ-027 A branch flush SHALL suppress load-use detection in the same cycle.
REQ-028 A branchTaken arriving in MEMWAIT SHALL be ignored; the frozen MEM stage re-presents it after release.
REQ-029 Load-use stall: idexMemRead=1, idexRegisterTarget!=0, and a match on ifidRegisterSource or ifidRegisterTarget SHALL assert the stall.
REQ-030 A load-use stall SHALL drive pcWrite=0, ifidWrite=0 and idexBubble=1 that cycle, and increment stallCount.
REQ-031 A load-use stall lasts exactly one cycle, because the bubble clears idexMemRead.
REQ-032 Register 0 SHALL never cause a stall.
REQ-033 stallCount and flushCount SHALL hold at 16'hFFFF once saturated.

Reset
REQ-034 Asserting reset SHALL immediately force the FSM to RUN and clear the wait counter, stallCount, flushCount and memTimeout to 0.
REQ-035 Reset asserted mid-MEMWAIT SHALL abort the wait; after release, outputs follow RUN defaults.

Structure
REQ-036 A shared package SHALL hold the RUN/MEMWAIT state encoding and the TIMEOUT default.
REQ-037 A sub-module sat_counter16 (16-bit enable-increment, saturating, async reset) SHALL be instantiated twice, for stallCount and flushCount.

Verification
REQ-038 Load-use: idexMemRead=1, idexRegisterTarget=5, ifidRegisterSource=5 -> one cycle of pcWrite=0, ifidWrite=0, idexBubble=1; stallCount=1.
REQ-039 Register 0: idexMemRead=1, target=0, source=0 -> no stall; stallCount stays 0.
REQ-040 Branch plus hazard: branchTaken=1 with a load-use match -> three flushes, no bubble; flushCount=1, stallCount=0.
REQ-041 Memory wait: memRequest=1 with memReady low for 3 cycles -> enables 0 for 3 cycles, then restored the cycle memReady=1; memTimeout=0.
REQ-042 Timeout and reset: TIMEOUT=4, memReady held low 6 cycles -> memTimeout=1 and stays set; reset pulse mid-wait -> RUN, all counters 0.
